sw_debounce: RTL
================

# sw_debounce

Input-side conditioning block for the board switches: synchronises the raw `sw` pins into the `clk_100_in` domain, debounces each channel with its own stability counter, and emits a clean level plus one-cycle rise and fall strobes per channel. It sits between the switch pins and any logic that consumes switch state, including the registered LED driver. It replaces direct sampling of `sw`.

## Interface
- `WIDTH`, 8: number of switch channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel; must be ≥2.
- `CNT_MAX`, 1_000_000: consecutive sampled cycles a new level must hold before acceptance (10 ms at 100 MHz); must be ≥1.
- `clk_100_in`  input  1  100 MHz system clock; all state is on its rising edge.
- `rst_in`  input  1  reset, asynchronous, active-high.
- `sw_in`  input  [0:WIDTH-1]  raw asynchronous switch pins.
- `sw_db`  output  [0:WIDTH-1]  debounced switch level.
- `sw_rise`  output  [0:WIDTH-1]  one-cycle strobe; `sw_db[i]` has just gone 0→1.
- `sw_fall`  output  [0:WIDTH-1]  one-cycle strobe; `sw_db[i]` has just gone 1→0.
- `sw_changed`  output  1  one-cycle strobe; any bit of `sw_rise | sw_fall` is set.

## Operation
- Reset while `rst_in`=1, asynchronously: all synchroniser flops, counters, `sw_db`, `sw_rise`, `sw_fall` and `sw_changed` are 0.
- Synchroniser: a `SYNC_STAGES`-deep flop chain per bit. The last stage, `sync[i]`, is the only value the debouncer reads.
- Per-channel counter is `$clog2(CNT_MAX+1)` bits wide. Each edge, per channel i, the first matching rule applies:
  - `sync[i] == sw_db[i]`: counter cleared to 0. A bounce back to the accepted level discards progress.
  - `sync[i] != sw_db[i]` and counter == `CNT_MAX-1`: `sw_db[i]` toggles and the counter clears. `sw_rise[i]` or `sw_fall[i]` is set to match the new level.
  - `sync[i] != sw_db[i]` otherwise: counter increments. It never exceeds `CNT_MAX-1`, so it cannot wrap.
- Strobes: `sw_rise`, `sw_fall` and `sw_changed` are registered and cleared on every edge that does not set them. Each lasts exactly one cycle per accepted transition.
- Channels are fully independent. Several channels may toggle on the same edge; all their strobes assert together and `sw_changed` is a single cycle.
- An accepted toggle and a new input change cannot conflict: the counter clears on the toggle edge, and the next transition needs a fresh `CNT_MAX` run.
- `sw_db` initialises to 0. A switch held high through reset therefore produces one `sw_rise` after full latency once reset releases. This is intended, and consumers treat it as the power-on event.

## Timing
- Latency: `sw_in[i]` changes and holds, first sampled at edge 0. `sync[i]` changes at edge `SYNC_STAGES-1`. `sw_db[i]` and the strobe update at edge `SYNC_STAGES+CNT_MAX-1`.
- With defaults, that is edge 1_000_001.
- Strobes are high for the cycle after the edge on which `sw_db` changes, aligned with the new `sw_db` value.
- Glitch rejection: any excursion on `sync[i]` lasting fewer than `CNT_MAX` cycles never reaches `sw_db`.
- Reset mid-count: progress is lost and outputs go to 0 immediately. After deassertion, the full latency applies again.
- No backpressure: outputs are free-running level and strobes, with no handshake.

## Test plan
Parameters for all scenarios: `WIDTH`=8, `SYNC_STAGES`=2, `CNT_MAX`=4, so latency = 5 edges.

- Reset values: assert `rst_in` with `sw_in`=8'hFF → all outputs 0 during reset, with no clock required.
- Clean press: release reset with `sw_in`=0, then set `sw_in`=8'h80 before edge 0.
  - `sw_db`=8'h80 after edge 5.
  - `sw_rise`=8'h80 and `sw_changed`=1 for exactly that one cycle.
  - `sw_fall` stays 0 throughout.
- Bounce rejection: toggle `sw_in[0]` as 1,0,1,0 over four single cycles, then hold 0 → `sw_db` stays 0 and no strobes occur.
- Bounce then settle: `sw_in[3]` high 3 cycles, low 1, then high indefinitely → `sw_db[3]` rises exactly 5 edges after the final 0→1 sample, with a single `sw_rise[3]` pulse.
- Release and simultaneous events: from `sw_db`=8'h81, set `sw_in`=8'h03.
  - On the same edge: `sw_fall`=8'h80 and `sw_rise`=8'h02.
  - `sw_changed` is high for one cycle.
  - `sw_db`=8'h03 afterwards.
- Reset mid-count: drive `sw_in`=8'hFF, then assert `rst_in` at edge 3 for 2 cycles and release.
  - `sw_db` is 0 throughout the reset.
  - After release, `sw_db`=8'hFF and `sw_rise`=8'hFF occur 5 edges after the first post-reset edge.

Source files
------------

// File: rtl/sw_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_if
// Brief    : Switch-pin and debounced-level bundle for sw_debounce.
// Revision : 1.0 - initial release
// ============================================================================
interface sw_debounce_if #(
  parameter int WIDTH = 8
);
  logic [0:WIDTH-1] sw_in;
  logic [0:WIDTH-1] sw_db;
  logic [0:WIDTH-1] sw_rise;
  logic [0:WIDTH-1] sw_fall;
  logic             sw_changed;

  modport master (output sw_in, input sw_db, sw_rise, sw_fall, sw_changed);
  modport slave  (input sw_in, output sw_db, sw_rise, sw_fall, sw_changed);
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Brief    : Per-channel switch synchroniser + stability-counter debouncer
//            with one-cycle rise/fall/changed strobes.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 1_000_000
) (
  input  wire logic    clk_100_in,
  input  wire logic    rst_in,
  sw_debounce_if.slave sw
);

  localparam int                 c_CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CNT_MAX - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("sw_debounce: SYNC_STAGES must be >= 2");
  end
  if (CNT_MAX < 1) begin : g_bad_cnt_max
    $error("sw_debounce: CNT_MAX must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync [WIDTH];
  logic [c_CNT_W-1:0]     r_cnt  [WIDTH];
  logic [0:WIDTH-1]       r_db;
  logic [0:WIDTH-1]       r_rise;
  logic [0:WIDTH-1]       r_fall;
  logic                   r_changed;

  logic [0:WIDTH-1]       w_sync;
  logic [0:WIDTH-1]       w_toggle;

  // A channel toggles once its new level has held for CNT_MAX sampled edges.
  always_comb begin
    w_sync   = '0;
    w_toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sync[i]   = r_sync[i][SYNC_STAGES-1];
      w_toggle[i] = (w_sync[i] != r_db[i]) && (r_cnt[i] == c_CNT_LAST);
    end
  end

  always_ff @(posedge clk_100_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_db      <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], sw.sw_in[i]};
        // Matching the accepted level or accepting a toggle both restart the run.
        if ((w_sync[i] == r_db[i]) || w_toggle[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
        end
      end
      r_db      <= r_db ^ w_toggle;
      r_rise    <= w_toggle & ~r_db;
      r_fall    <= w_toggle & r_db;
      r_changed <= |w_toggle;
    end
  end

  assign sw.sw_db      = r_db;
  assign sw.sw_rise    = r_rise;
  assign sw.sw_fall    = r_fall;
  assign sw.sw_changed = r_changed;

endmodule
`default_nettype wire
